fetch_unit: RTL and testbench

Instruction fetch stage of the 8-bit MCU, directly upstream of the instruction decoder. Keeps the program counter, reads 8-bit instructions from a synchronous program memory with one-cycle read latency, and presents one instruction per cycle with a valid/stall handshake. Handles taken-branch redirects from execute and stops fetching on the HALT opcode.

---
 rtl/mcu_pkg.sv | 29 ++
 rtl/fetch_skid.sv | 28 ++
 rtl/fetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared definitions for the 8-bit MCU: widths, opcodes, fetch state and
// the instruction/address pair that moves through the fetch stage.
package mcu_pkg;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 8;
  localparam int OP_W    = 4;

  localparam logic [OP_W-1:0] OP_NOP  = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD  = 4'b0001;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0010;
  localparam logic [OP_W-1:0] OP_LD   = 4'b0011;
  localparam logic [OP_W-1:0] OP_ST   = 4'b0100;
  localparam logic [OP_W-1:0] OP_MOVI = 4'b0101;
  localparam logic [OP_W-1:0] OP_JMP  = 4'b1000;
  localparam logic [OP_W-1:0] OP_BEQ  = 4'b1001;
  localparam logic [OP_W-1:0] OP_HALT = 4'b1111;

  typedef enum logic [1:0] {BOOT, RUN, HALTED} fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  // Opcode lives in the upper nibble of every instruction.
  function automatic logic [OP_W-1:0] opcode_of(input logic [INSTR_W-1:0] i);
    return i[INSTR_W-1 -: OP_W];
  endfunction
endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer catching the single read that lands while the
// output is stalled. Clear wins over push, push wins over pop.
module fetch_skid
  import mcu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t din,
  output logic         valid,
  output fetch_entry_t dout
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (push) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, read issue to a 1-cycle synchronous program memory,
// output register with skid, branch redirect and HALT handling.
module fetch_unit
  import mcu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_rd_en,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               halted
);
  fetch_state_e      state;
  logic [ADDR_W-1:0] pc, pend_pc;
  logic              pending;
  logic              out_valid;
  fetch_entry_t      out_q, ret, cur, skid_q;
  logic              cur_valid, skid_valid, issue, xfer, halt_hit;
  logic              skid_push, skid_pop, skid_clr;

  assign ret = '{instr: imem_rdata, pc: pend_pc};

  // Returning data is shown straight from memory when the output register is
  // empty; it is only registered once it has to be held.
  always_comb begin
    cur       = out_q;
    cur_valid = out_valid;
    if (!out_valid && pending) begin
      cur       = ret;
      cur_valid = 1'b1;
    end
  end

  assign instr       = cur.instr;
  assign instr_pc    = cur.pc;
  assign instr_valid = cur_valid;
  assign xfer        = cur_valid & ~stall;

  // Gating on the registered output lets the read issued in the first stall
  // cycle land in the skid; after that nothing issues until it drains.
  assign issue      = (state == RUN) & ~skid_valid & ~(out_valid & stall) & ~redirect;
  assign imem_rd_en = issue;
  assign imem_addr  = pc;

  assign halt_hit  = (state == RUN) & cur_valid & (opcode_of(cur.instr) == OP_HALT);
  assign skid_clr  = redirect | halt_hit;
  assign skid_push = (state == RUN) & out_valid & stall & pending;
  assign skid_pop  = (state == RUN) & out_valid & ~stall & skid_valid;

  fetch_skid u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (skid_clr),
    .push  (skid_push),
    .pop   (skid_pop),
    .din   (ret),
    .valid (skid_valid),
    .dout  (skid_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      pending   <= 1'b0;
      pend_pc   <= '0;
      out_valid <= 1'b0;
      out_q     <= '0;
      halted    <= 1'b0;
    end else if (redirect) begin
      state     <= RUN;
      halted    <= 1'b0;
      pc        <= redirect_pc;
      pending   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      pending <= issue;
      pend_pc <= pc;
      if (issue) pc <= pc + 1'b1;
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (halt_hit) begin
            // Keep only the HALT itself; anything behind it is dropped.
            state     <= HALTED;
            halted    <= 1'b1;
            pending   <= 1'b0;
            out_q     <= cur;
            out_valid <= stall;
          end else if (out_valid) begin
            if (!stall) begin
              if (skid_valid)   out_q <= skid_q;
              else if (pending) out_q <= ret;
              out_valid <= skid_valid | pending;
            end
          end else if (pending && stall) begin
            out_q     <= ret;
            out_valid <= 1'b1;
          end
        end
        HALTED: if (xfer) out_valid <= 1'b0;
        default: state <= BOOT;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed timing scenarios followed by a randomized
// stall/redirect run, all checked against a program-order reference model.
module tb_fetch_unit;
  import mcu_pkg::*;

  localparam logic [7:0] RST_PC = 8'h00;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] imem_addr, imem_rdata, instr, instr_pc, redirect_pc;
  logic       imem_rd_en, instr_valid, stall, redirect, halted;

  logic [7:0] mem [256];
  int n_chk = 0;
  int n_err = 0;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_addr  (imem_addr),
    .imem_rd_en (imem_rd_en),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  // Synchronous program memory, one-cycle read latency.
  always @(posedge clk) if (imem_rd_en) imem_rdata <= mem[imem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_halt(input logic [7:0] b);
    return b[7:4] == OP_HALT;
  endfunction

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // Reference model: the instruction stream is program order from the last
  // redirect target, ending after a HALT is taken.
  logic [7:0] exp_pc, h_instr, h_pc, tgt1, tgt2;
  logic       m_halted, stopped, hold;
  logic [1:0] red_hist;
  int         n_deliv = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pc   <= RST_PC;
      m_halted <= 1'b0;
      stopped  <= 1'b0;
      hold     <= 1'b0;
      red_hist <= 2'b00;
    end else begin
      chk("halted", 32'(halted), 32'(m_halted));
      if (m_halted) chk("no_rd_halted", 32'(imem_rd_en), 32'd0);
      if (hold) begin
        chk("hold_valid", 32'(instr_valid), 32'd1);
        chk("hold_instr", 32'(instr), 32'(h_instr));
        chk("hold_pc", 32'(instr_pc), 32'(h_pc));
      end
      if (red_hist[0]) chk("redir_bubble", 32'(instr_valid), 32'd0);
      else if (red_hist[1]) begin
        chk("redir_valid", 32'(instr_valid), 32'd1);
        chk("redir_pc", 32'(instr_pc), 32'(tgt2));
      end
      if (stopped) chk("after_halt", 32'(instr_valid), 32'd0);
      if (instr_valid) begin
        chk("seq_pc", 32'(instr_pc), 32'(exp_pc));
        chk("seq_instr", 32'(instr), 32'(mem[exp_pc]));
      end
      m_halted <= !redirect && (m_halted || (instr_valid && is_halt(mem[exp_pc])));
      red_hist <= {red_hist[0], redirect};
      tgt2     <= tgt1;
      tgt1     <= redirect_pc;
      if (redirect) begin
        exp_pc  <= redirect_pc;
        stopped <= 1'b0;
        hold    <= 1'b0;
      end else begin
        hold    <= instr_valid && stall;
        h_instr <= instr;
        h_pc    <= instr_pc;
        if (instr_valid && !stall) begin
          exp_pc  <= exp_pc + 8'd1;
          n_deliv <= n_deliv + 1;
          if (is_halt(mem[exp_pc])) stopped <= 1'b1;
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_en"}, 32'(imem_rd_en), 32'd0);
    chk({tag, "_addr"}, 32'(imem_addr), 32'(RST_PC));
    chk({tag, "_instr"}, 32'(instr), 32'h00);
    chk({tag, "_pc"}, 32'(instr_pc), 32'h00);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
  endtask

  // Called right after reset release: cycle 0 idle, cycle 1 read, cycle 2 valid.
  task automatic boot_seq;
    @(negedge clk);
    chk("boot_rd", 32'(imem_rd_en), 32'd0);
    chk("boot_valid", 32'(instr_valid), 32'd0);
    next_cycle;
    @(negedge clk);
    chk("first_rd", 32'(imem_rd_en), 32'd1);
    chk("first_addr", 32'(imem_addr), 32'(RST_PC));
    next_cycle;
    @(negedge clk);
    chk("first_valid", 32'(instr_valid), 32'd1);
    chk("first_pc", 32'(instr_pc), 32'(RST_PC));
    chk("first_instr", 32'(instr), 32'(mem[RST_PC]));
  endtask

  initial begin
    int n_rd;
    int n0;
    logic [7:0] a;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 8'h00;
    for (int i = 0; i < 256; i++)
      mem[i] = {4'($urandom_range(0, 14)), 4'($urandom_range(0, 15))};
    for (int i = 0; i < 5; i++) mem[i] = 8'h10 + 8'(i);
    mem[5] = 8'hF0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1 rst_n = 1'b1;

    // Free run: 10..13 on consecutive cycles from cycle 2.
    boot_seq();
    for (int k = 1; k < 4; k++) begin
      next_cycle;
      @(negedge clk);
      chk("run_valid", 32'(instr_valid), 32'd1);
      chk("run_pc", 32'(instr_pc), 32'(k));
      chk("run_instr", 32'(instr), 32'h10 + 32'(k));
    end

    // Three-cycle stall on address 4.
    next_cycle;
    stall = 1'b1;
    n_rd = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_rd += int'(imem_rd_en);
      chk("stall_pc", 32'(instr_pc), 32'h04);
      next_cycle;
    end
    stall = 1'b0;
    @(negedge clk);
    chk("skid_absorb", 32'(n_rd), 32'd1);
    chk("rel_no_rd", 32'(imem_rd_en), 32'd0);
    chk("rel_pc", 32'(instr_pc), 32'h04);
    next_cycle;
    @(negedge clk);
    chk("skid_pc", 32'(instr_pc), 32'h05);
    chk("skid_instr", 32'(instr), 32'hF0);
    chk("rel_issue", 32'(imem_rd_en), 32'd1);
    next_cycle;
    @(negedge clk);
    chk("halt_rise", 32'(halted), 32'd1);
    chk("halt_novalid", 32'(instr_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      next_cycle;
      @(negedge clk);
      chk("halt_no_rd", 32'(imem_rd_en), 32'd0);
    end

    // Redirect out of HALTED to 0.
    next_cycle;
    redirect = 1'b1;
    redirect_pc = 8'h00;
    next_cycle;
    redirect = 1'b0;
    @(negedge clk);
    chk("resume_halted", 32'(halted), 32'd0);
    chk("resume_bubble", 32'(instr_valid), 32'd0);
    next_cycle;
    @(negedge clk);
    chk("resume_pc", 32'(instr_pc), 32'h00);
    chk("resume_instr", 32'(instr), 32'h10);

    // Fill the skid, then redirect to 8'h40 while still stalled.
    next_cycle;
    stall = 1'b1;
    @(negedge clk);
    chk("pre_redir_pc", 32'(instr_pc), 32'h01);
    next_cycle;
    next_cycle;
    redirect = 1'b1;
    redirect_pc = 8'h40;
    next_cycle;
    redirect = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    chk("r40_bubble", 32'(instr_valid), 32'd0);
    next_cycle;
    @(negedge clk);
    chk("r40_valid", 32'(instr_valid), 32'd1);
    chk("r40_pc", 32'(instr_pc), 32'h40);
    chk("r40_instr", 32'(instr), 32'(mem[8'h40]));

    // PC wrap through 8'hFF.
    next_cycle;
    redirect = 1'b1;
    redirect_pc = 8'hFE;
    next_cycle;
    redirect = 1'b0;
    for (int k = 0; k < 3; k++) begin
      next_cycle;
      @(negedge clk);
      a = 8'hFE + 8'(k);
      chk("wrap_valid", 32'(instr_valid), 32'd1);
      chk("wrap_pc", 32'(instr_pc), 32'(a));
      chk("wrap_instr", 32'(instr), 32'(mem[a]));
    end

    // Async reset mid-stall with the skid full.
    next_cycle;
    stall = 1'b1;
    next_cycle;
    next_cycle;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    stall = 1'b0;
    for (int k = 0; k < 3; k++) mem[8'h60 + 8'($urandom_range(0, 127))] = 8'hF5;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    boot_seq();

    // Randomized stall/redirect traffic.
    n0 = n_deliv;
    for (int k = 0; k < 800; k++) begin
      next_cycle;
      stall = ($urandom_range(0, 3) == 0);
      redirect = ($urandom_range(0, 19) == 0);
      redirect_pc = 8'($urandom_range(0, 255));
    end
    next_cycle;
    stall = 1'b0;
    redirect = 1'b0;
    repeat (3) next_cycle;
    chk("liveness", 32'(n_deliv - n0 > 100), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
